// File: rtl/if_stage.sv
// if_stage: instruction fetch stage; owns the PC, issues req/gnt/rvalid fetches,
// buffers {pc, instr} pairs for decode, and handles redirect, stall and halt.
// Optional IF_MISALIGN_CHECK_EN adds fetch_misalign_o and halts on a misaligned redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    input  logic        halt_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        halted_o
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misalign_o
`endif
);
    localparam int            AW  = $clog2(DEPTH);
    localparam int            CW  = AW + 1;
    localparam logic [CW-1:0] CAP = CW'(DEPTH);
    localparam logic [31:0]   NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t        state, state_nx;
    logic          held, pend;
    logic [31:0]   pend_pc, last_pc, target;
    logic [CW-1:0] outstanding, discard, count;
    logic [AW-1:0] oq_rd, oq_wr, buf_rd, buf_wr;
    logic [31:0]   oq [DEPTH];
    logic [31:0]   buf_pc [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic          fire, wait_req, rv, drop, push, pop, flush, mis, take;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign;
    assign mis              = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign fetch_misalign_o = misalign;
    // misaligned redirects latch a sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign <= 1'b0;
        else     misalign <= misalign | mis;
    end
`else
    logic unused_lsb;
    assign mis        = 1'b0;
    assign unused_lsb = ^redirect_pc_i[1:0];
`endif

    assign target     = {redirect_pc_i[31:2], 2'b00};
    assign take       = redirect_i && !mis;
    // a request once raised stays up until granted, even across halt/redirect
    assign imem_req_o = held || (state == RUN && (outstanding + count) < CAP);
    assign fire       = imem_req_o && imem_gnt_i;
    assign wait_req   = imem_req_o && !imem_gnt_i;
    // responses with nothing outstanding (e.g. arriving after reset) are ignored
    assign rv         = imem_rvalid_i && outstanding != '0;
    assign drop       = rv && discard != '0;
    assign flush      = redirect_i && state != HALT;
    assign valid_o    = count != '0;
    assign push       = rv && !drop && !flush;
    assign pop        = valid_o && !stall_i && !flush;
    assign instr_o    = valid_o ? buf_instr[buf_rd] : NOP;
    assign pc_o       = valid_o ? buf_pc[buf_rd] : last_pc;
    assign halted_o   = state == HALT;

    // BOOT lasts one cycle; HALT is sticky until reset
    always_comb begin
        state_nx = (mis || (state == RUN && halt_i)) ? HALT : (state == BOOT ? RUN : state);
    end

    // fetch address, outstanding/discard tracking and buffer occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            held        <= 1'b0;
            pend        <= 1'b0;
            pend_pc     <= RESET_PC;
            imem_addr_o <= RESET_PC;
            last_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            oq_rd       <= '0;
            oq_wr       <= '0;
            buf_rd      <= '0;
            buf_wr      <= '0;
        end else begin
            state       <= state_nx;
            held        <= wait_req;
            last_pc     <= pc_o;
            outstanding <= outstanding + CW'(fire) - CW'(rv);
            oq_wr       <= oq_wr + AW'(fire);
            oq_rd       <= oq_rd + AW'(rv);
            if (take && wait_req) begin
                pend    <= 1'b1;
                pend_pc <= target;
            end else if (take) begin
                pend        <= 1'b0;
                imem_addr_o <= target;
            end else if (fire) begin
                pend        <= 1'b0;
                imem_addr_o <= pend ? pend_pc : imem_addr_o + 32'd4;
            end
            if (flush) begin
                discard <= outstanding - CW'(rv) + CW'(imem_req_o);
                count   <= '0;
                buf_wr  <= buf_rd;
            end else begin
                discard <= discard - CW'(drop);
                count   <= count + CW'(push) - CW'(pop);
                buf_wr  <= buf_wr + AW'(push);
                buf_rd  <= buf_rd + AW'(pop);
            end
        end
    end

    // storage for in-flight PCs and buffered instructions; contents gated by counts
    always_ff @(posedge clk) begin
        if (fire) oq[oq_wr] <= imem_addr_o;
        if (push) begin
            buf_pc[buf_wr]    <= oq[oq_rd];
            buf_instr[buf_wr] <= imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios with a queue scoreboard checked by a separate monitor.
module tb_if_stage;
    localparam logic [31:0] TAG = 32'hA000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect = 1'b0, stall = 1'b0, halt = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid, halted;
    logic [31:0] instr, pc;
    logic        req2, valid2, halted2;
    logic [31:0] addr2, instr2, pc2;

    int          passed = 0, total = 0, budget = 0;
    logic        gp = 1'b0, rv_en = 1'b0;
    logic [31:0] resp_q[$], glog[$], exp_q[$];

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .stall_i(stall), .halt_i(halt),
        .valid_o(valid), .instr_o(instr), .pc_o(pc), .halted_o(halted)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(1'b1),
        .imem_rvalid_i(1'b0), .imem_rdata_i(32'h0),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .stall_i(1'b0), .halt_i(1'b0),
        .valid_o(valid2), .instr_o(instr2), .pc_o(pc2), .halted_o(halted2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    // memory: one-cycle-minimum latency, in-order, grants limited by budget
    initial forever begin
        @(negedge clk); #2;
        if (rv_en && resp_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = TAG | resp_q.pop_front();
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        imem_gnt = gp && budget > 0;
        if (imem_req && imem_gnt) begin
            resp_q.push_back(imem_addr);
            glog.push_back(imem_addr);
            budget--;
        end
    end

    // monitor: every instruction consumed by decode is checked against the scoreboard
    initial begin
        logic [31:0] p;
        forever begin
            @(negedge clk); #4;
            if (valid && !stall) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_out: got pc %h want none", pc);
                end else begin
                    p = exp_q.pop_front();
                    chk("out_pc", pc, p);
                    chk("out_instr", instr, TAG | p);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", halted, 0);
        rst = 1'b0;
        exp_q.delete();
        glog.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // A: streaming fetch, plus wrap of the second instance
        do_reset();
        gp = 1; rv_en = 1; budget = 4;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        @(negedge clk); #4;
        chk("a_req_k1", imem_req, 1);
        chk("wrap_first", addr2, 32'hFFFF_FFFC);
        @(negedge clk); #4;
        chk("a_valid_k2", valid, 0);
        chk("wrap_second", addr2, 32'h0000_0000);
        chk("wrap_valid", valid2, 0);
        chk("wrap_instr", instr2, NOP);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_halted", halted2, 0);
        @(negedge clk); #4;
        chk("a_valid_k3", valid, 1);
        chk("a_pc_k3", pc, 32'h0);
        drain("a_drain");
        chk("a_grants", 32'(glog.size()), 4);
        for (int i = 0; i < 3; i++) chk("a_grant_addr", glog[i], 32'(i * 4));

        // B: stall with memory always granting
        do_reset();
        stall = 1; gp = 1; rv_en = 1; budget = 6;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        repeat (5) @(negedge clk);
        #4;
        chk("b_req_stalled", imem_req, 0);
        chk("b_valid_stalled", valid, 1);
        chk("b_pc_held", pc, 32'h0);
        @(negedge clk);
        stall = 0;
        drain("b_drain");
        chk("b_grants", 32'(glog.size()), 6);

        // C: redirect with two responses in flight
        do_reset();
        gp = 1; rv_en = 0; budget = 4;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        repeat (3) @(negedge clk);
        redirect = 1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 0; rv_en = 1;
        #4;
        chk("c_req_full", imem_req, 0);
        chk("c_valid_flushed", valid, 0);
        drain("c_drain");
        chk("c_grant_target", glog[2], 32'h100);

        // D: ungranted request held across a redirect
        do_reset();
        gp = 0; rv_en = 1; budget = 3;
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        @(negedge clk); #4;
        chk("d_req_k1", imem_req, 1);
        chk("d_addr_k1", imem_addr, 32'h0);
        @(negedge clk);
        redirect = 1; redirect_pc = 32'h40;
        #4;
        chk("d_addr_k2", imem_addr, 32'h0);
        @(negedge clk);
        redirect = 0;
        #4;
        chk("d_req_k3", imem_req, 1);
        chk("d_addr_k3", imem_addr, 32'h0);
        @(negedge clk);
        gp = 1;
        @(negedge clk); #4;
        chk("d_req_k5", imem_req, 1);
        chk("d_addr_k5", imem_addr, 32'h40);
        drain("d_drain");

        // E: halt with one outstanding, then redirect while halted
        do_reset();
        gp = 1; rv_en = 0; budget = 10;
        exp_q.push_back(32'h0);
        @(negedge clk);
        halt = 1;
        #4;
        chk("e_req_k1", imem_req, 1);
        @(negedge clk);
        halt = 0; rv_en = 1;
        #4;
        chk("e_halted", halted, 1);
        chk("e_req_k2", imem_req, 0);
        @(negedge clk); #4;
        chk("e_valid_k3", valid, 1);
        chk("e_req_k3", imem_req, 0);
        @(negedge clk);
        redirect = 1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 0;
        #4;
        chk("e_req_k5", imem_req, 0);
        chk("e_halted_k5", halted, 1);
        chk("e_addr_k5", imem_addr, 32'h200);
        chk("e_valid_k5", valid, 0);
        drain("e_drain");
        chk("e_grants", 32'(glog.size()), 1);

        // G: reset with a response in flight and a held request
        do_reset();
        gp = 1; rv_en = 0; budget = 1;
        @(negedge clk);
        @(negedge clk); #4;
        chk("g_held_req", imem_req, 1);
        chk("g_held_addr", imem_addr, 32'h4);
        do_reset();
        rv_en = 1; gp = 1; budget = 2;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        @(negedge clk); #4;
        chk("g_valid_k1", valid, 0);
        chk("g_req_k1", imem_req, 1);
        chk("g_addr_k1", imem_addr, 32'h0);
        drain("g_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
